vc_skid_buffer: RTL and testbench

VC_SKID_BUFFER -- requirements
Module: vc_skid_buffer

---
 rtl/vc_skid_buffer.sv | 66 ++++++
 tb/tb_vc_skid_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vc_skid_buffer.sv
// Two-entry valid/ready skid buffer with strict FIFO ordering.
// Define VC_SKID_BUFFER_BYPASS_EN to let a message pass straight through when empty.
module vc_skid_buffer #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         num_free
);

  logic [p_nbits-1:0] entry_q [2];
  logic               enq_ptr_q, enq_ptr_d;
  logic               deq_ptr_q, deq_ptr_d;
  logic [1:0]         count_q, count_d;

  logic enq_fire, deq_fire, bypass, wr_en, rd_adv;

  assign enq_rdy  = reset && (count_q != 2'd2);
  assign num_free = 2'd2 - count_q;

`ifdef VC_SKID_BUFFER_BYPASS_EN
  // Empty buffer presents the upstream message directly.
  assign deq_val = reset && ((count_q != 2'd0) || enq_val);
  assign deq_msg = (count_q == 2'd0) ? enq_msg : entry_q[deq_ptr_q];
  assign bypass  = (count_q == 2'd0) && enq_fire && deq_fire;
`else
  assign deq_val = reset && (count_q != 2'd0);
  assign deq_msg = entry_q[deq_ptr_q];
  assign bypass  = 1'b0;
`endif

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign wr_en    = enq_fire && !bypass;
  assign rd_adv   = deq_fire && !bypass;

  always_comb begin
    enq_ptr_d = enq_ptr_q ^ wr_en;
    deq_ptr_d = deq_ptr_q ^ rd_adv;
    count_d   = count_q + {1'b0, wr_en} - {1'b0, rd_adv};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= 2'd0;
      enq_ptr_q <= 1'b0;
      deq_ptr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
    end
  end

  // Storage is intentionally unreset; count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) entry_q[enq_ptr_q] <= enq_msg;
  end

endmodule

// File: tb/tb_vc_skid_buffer.sv
// Directed vector bench for vc_skid_buffer (8-bit messages).
module tb_vc_skid_buffer;

  logic       clk = 1'b0;
  logic       reset, enq_val, enq_rdy, deq_val, deq_rdy;
  logic [7:0] enq_msg, deq_msg;
  logic [1:0] num_free;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vc_skid_buffer #(.p_nbits(8)) dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
    .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
    .num_free(num_free)
  );

  typedef struct {
    logic       rst;
    logic       ev;
    logic [7:0] msg;
    logic       dr;
    logic       e_erdy;
    logic       e_dval;
    logic       chk_msg;
    logic [7:0] e_msg;
    logic       chk_nf;
    logic [1:0] e_nf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ev, input logic [7:0] m, input logic dr);
    @(negedge clk);
    reset = r; enq_val = ev; enq_msg = m; deq_rdy = dr;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic er, input logic dv,
                         input logic cm, input logic [7:0] em,
                         input logic cn, input logic [1:0] en);
    chk({tag, ".enq_rdy"}, {7'd0, enq_rdy}, {7'd0, er});
    chk({tag, ".deq_val"}, {7'd0, deq_val}, {7'd0, dv});
    if (cm) chk({tag, ".deq_msg"}, deq_msg, em);
    if (cn) chk({tag, ".num_free"}, {6'd0, num_free}, {6'd0, en});
  endtask

  function automatic vec_t mk(logic rst, logic ev, logic [7:0] msg, logic dr,
                              logic er, logic dv, logic cm, logic [7:0] em,
                              logic cn, logic [1:0] en);
    vec_t v;
    v = '{rst, ev, msg, dr, er, dv, cm, em, cn, en};
    return v;
  endfunction

  initial begin
    reset = 1'b0; enq_val = 1'b0; enq_msg = 8'h00; deq_rdy = 1'b0;

    // reset held with enq_val=1; outputs forced low, num_free unknown before first edge
    vecs.push_back(mk(0, 1, 8'h11, 0,  0, 0, 0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(0, 1, 8'h11, 1,  0, 0, 0, 8'h00, 1, 2'd2));
    vecs.push_back(mk(1, 0, 8'h00, 0,  1, 0, 0, 8'h00, 1, 2'd2));
`ifndef VC_SKID_BUFFER_BYPASS_EN
    // fill with A,B under backpressure, then drain in order
    vecs.push_back(mk(1, 1, 8'h0A, 0,  1, 0, 0, 8'h00, 1, 2'd2));
    vecs.push_back(mk(1, 1, 8'h0B, 0,  1, 1, 1, 8'h0A, 1, 2'd1));
    vecs.push_back(mk(1, 1, 8'h0C, 0,  0, 1, 1, 8'h0A, 1, 2'd0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  0, 1, 1, 8'h0A, 1, 2'd0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 1, 8'h0B, 1, 2'd1));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 2'd2));
    // streaming 1..8: one-cycle latency, then one per cycle at count 1
    vecs.push_back(mk(1, 1, 8'h01, 1,  1, 0, 0, 8'h00, 1, 2'd2));
    for (int k = 2; k <= 8; k++)
      vecs.push_back(mk(1, 1, 8'(k), 1,  1, 1, 1, 8'(k-1), 1, 2'd1));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 1, 8'h08, 1, 2'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0,  1, 0, 0, 8'h00, 1, 2'd2));
    // full with deq_rdy=1 and enq_val=1: deq only, enq lands next cycle
    vecs.push_back(mk(1, 1, 8'h21, 0,  1, 0, 0, 8'h00, 1, 2'd2));
    vecs.push_back(mk(1, 1, 8'h22, 0,  1, 1, 1, 8'h21, 1, 2'd1));
    vecs.push_back(mk(1, 1, 8'h23, 1,  0, 1, 1, 8'h21, 1, 2'd0));
    vecs.push_back(mk(1, 1, 8'h23, 0,  1, 1, 1, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 8'h00, 1,  0, 1, 1, 8'h22, 1, 2'd0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 1, 8'h23, 1, 2'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0,  1, 0, 0, 8'h00, 1, 2'd2));
    // reset while holding two entries discards them
    vecs.push_back(mk(1, 1, 8'h31, 0,  1, 0, 0, 8'h00, 1, 2'd2));
    vecs.push_back(mk(1, 1, 8'h32, 0,  1, 1, 1, 8'h31, 1, 2'd1));
    vecs.push_back(mk(0, 1, 8'h33, 1,  0, 0, 0, 8'h00, 1, 2'd0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 2'd2));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 2'd2));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].msg, vecs[i].dr);
      chk_out($sformatf("vec%0d", i), vecs[i].e_erdy, vecs[i].e_dval,
              vecs[i].chk_msg, vecs[i].e_msg, vecs[i].chk_nf, vecs[i].e_nf);
    end

`ifndef VC_SKID_BUFFER_BYPASS_EN
    // no combinational enq->deq path when empty
    drive(1, 1, 8'h41, 1);
    chk_out("nobyp", 1, 0, 0, 8'h00, 1, 2'd2);
    drive(1, 1, 8'h42, 0);
    chk_out("fill2", 1, 1, 1, 8'h41, 1, 2'd1);
    // stalled head must stay stable while upstream keeps pushing
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 8'($urandom_range(255)), 0);
      chk_out($sformatf("stall%0d", c), 0, 1, 1, 8'h41, 1, 2'd0);
    end
    drive(1, 0, 8'h00, 1);
    chk_out("drain0", 0, 1, 1, 8'h41, 1, 2'd0);
    drive(1, 0, 8'h00, 1);
    chk_out("drain1", 1, 1, 1, 8'h42, 1, 2'd1);
    drive(1, 0, 8'h00, 0);
    chk_out("empty", 1, 0, 0, 8'h00, 1, 2'd2);
`else
    // empty + deq_rdy: same-cycle pass-through, storage untouched
    drive(1, 1, 8'h55, 1);
    chk_out("byp", 1, 1, 1, 8'h55, 1, 2'd2);
    drive(1, 0, 8'h00, 0);
    chk_out("byp_after", 1, 0, 0, 8'h00, 1, 2'd2);
    // empty + backpressure: message is stored
    drive(1, 1, 8'h55, 0);
    chk_out("byp_stall", 1, 1, 1, 8'h55, 1, 2'd2);
    drive(1, 0, 8'h00, 0);
    chk_out("stored", 1, 1, 1, 8'h55, 1, 2'd1);
    drive(1, 0, 8'h00, 1);
    chk_out("stored_deq", 1, 1, 1, 8'h55, 1, 2'd1);
    drive(1, 0, 8'h00, 0);
    chk_out("empty", 1, 0, 0, 8'h00, 1, 2'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
